data_mem_responder: RTL and testbench



---
 rtl/data_mem_if.sv | 40 ++++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the CPU datapath/controller and
// the data memory responder.
// Ports (signals): MemRead/MemWrite strobes, byte Address and WriteData from the
// requester; ReadData, MemReady, AddrError and Busy back from the memory.
interface data_mem_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  MemRead;
   logic                  MemWrite;
   logic [31:0]           Address;
   logic [DATA_WIDTH-1:0] WriteData;
   logic [DATA_WIDTH-1:0] ReadData;
   logic                  MemReady;
   logic                  AddrError;
   logic                  Busy;

   // Requester side (CPU).
   modport master (
      output MemRead,
      output MemWrite,
      output Address,
      output WriteData,
      input  ReadData,
      input  MemReady,
      input  AddrError,
      input  Busy
   );

   // Memory side (responder).
   modport slave (
      input  MemRead,
      input  MemWrite,
      input  Address,
      input  WriteData,
      output ReadData,
      output MemReady,
      output AddrError,
      output Busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed RAM behind a MemRead/MemWrite strobe interface.
// Latency: acceptance edge + WAIT_CYCLES edges, then a one-cycle MemReady pulse (RESP).
// Backpressure: strobes are level-held by the requester until MemReady; none issued by memory.
// Ports: clk, reset (sync, active-high); bus (data_mem_if.slave) carries MemRead, MemWrite,
//        Address, WriteData in and ReadData, MemReady, AddrError, Busy out.
module data_mem_responder #(
   parameter int ADDR_BITS   = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic      clk,
   input  logic      reset,
   data_mem_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int         DEPTH     = 2 ** ADDR_BITS;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   // Backing storage; intentionally not cleared by reset.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]  idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic                  is_wr_q, is_wr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

   logic                  entering_resp;
   logic                  mem_wr_en;

   // Only the word-index bits of the address are decoded; upper bits alias.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^bus.Address[31:ADDR_BITS+2];

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      wdat_d        = wdat_q;
      is_wr_d       = is_wr_q;
      err_d         = err_q;
      rdat_d        = rdat_q;
      entering_resp = 1'b0;
      mem_wr_en     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.MemRead || bus.MemWrite) begin
               idx_d   = bus.Address[ADDR_BITS+1:2];
               wdat_d  = bus.WriteData;
               is_wr_d = bus.MemWrite;
               err_d   = (bus.MemRead && bus.MemWrite) || (bus.Address[1:0] != 2'b00);
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Counter starts at WAIT_CYCLES; leaving on the count of 1 keeps the
            // request in WAIT for exactly WAIT_CYCLES cycles.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The RAM access happens on the edge that enters RESP. The _d copies of the
      // request are used so the zero-wait case (latch and enter RESP on the same
      // edge) and the waited case share one path.
      entering_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
      if (entering_resp && !err_d) begin
         if (is_wr_d) begin
            mem_wr_en = 1'b1;
         end else begin
            rdat_d = mem[idx_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdat_q  <= '0;
         is_wr_q <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdat_q  <= wdat_d;
         is_wr_q <= is_wr_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
      end
   end

   // A reset landing on the commit edge aborts the write.
   always_ff @(posedge clk) begin
      if (!reset && mem_wr_en) begin
         mem[idx_d] <= wdat_d;
      end
   end

   assign bus.ReadData  = rdat_q;
   assign bus.MemReady  = (state_q == ST_RESP);
   assign bus.AddrError = (state_q == ST_RESP) && err_q;
   assign bus.Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   data_mem_if #(.DATA_WIDTH(32)) if2 ();
   data_mem_if #(.DATA_WIDTH(32)) if0 ();

   data_mem_responder #(.ADDR_BITS(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (if2)
   );

   data_mem_responder #(.ADDR_BITS(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on the WAIT_CYCLES=2 instance, checked cycle by cycle.
   task automatic req2(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd);
      @(negedge clk);
      if2.MemRead   = rd;
      if2.MemWrite  = wr;
      if2.Address   = addr;
      if2.WriteData = wd;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check({tag, "_busy"}, 32'(if2.Busy), 32'd1);
         check({tag, "_rdy"}, 32'(if2.MemReady), 32'(c == 3));
         if (c == 3) begin
            check({tag, "_err"}, 32'(if2.AddrError), 32'(exp_err));
            check({tag, "_rdata"}, if2.ReadData, exp_rd);
         end
      end
      if2.MemRead  = 1'b0;
      if2.MemWrite = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_after"}, 32'(if2.MemReady), 32'd0);
      check({tag, "_busy_after"}, 32'(if2.Busy), 32'd0);
      check({tag, "_rdata_held"}, if2.ReadData, exp_rd);
   endtask

   // One transaction on the WAIT_CYCLES=0 instance.
   task automatic req0(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
      @(negedge clk);
      if0.MemRead   = rd;
      if0.MemWrite  = wr;
      if0.Address   = addr;
      if0.WriteData = wd;
      @(negedge clk);
      check({tag, "_rdy"}, 32'(if0.MemReady), 32'd1);
      check({tag, "_busy"}, 32'(if0.Busy), 32'd1);
      check({tag, "_err"}, 32'(if0.AddrError), 32'd0);
      check({tag, "_rdata"}, if0.ReadData, exp_rd);
      if0.MemRead  = 1'b0;
      if0.MemWrite = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_after"}, 32'(if0.MemReady), 32'd0);
      check({tag, "_busy_after"}, 32'(if0.Busy), 32'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      if2.MemRead   = 1'b0;
      if2.MemWrite  = 1'b0;
      if2.Address   = 32'h0;
      if2.WriteData = 32'h0;
      if0.MemRead   = 1'b0;
      if0.MemWrite  = 1'b0;
      if0.Address   = 32'h0;
      if0.WriteData = 32'h0;

      // Reset state of both instances.
      repeat (3) @(negedge clk);
      check("rst_rdata2", if2.ReadData, 32'h0);
      check("rst_rdy2", 32'(if2.MemReady), 32'd0);
      check("rst_err2", 32'(if2.AddrError), 32'd0);
      check("rst_busy2", 32'(if2.Busy), 32'd0);
      check("rst_rdata0", if0.ReadData, 32'h0);
      check("rst_busy0", 32'(if0.Busy), 32'd0);
      reset = 1'b0;

      // Writes, then reads back; latency identical for both directions.
      req2("wr20", 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
      req2("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      req2("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      // Error requests: AddrError with MemReady, ReadData held, RAM untouched.
      req2("rd13_mis", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'hDEADBEEF);
      req2("both10", 1'b1, 1'b1, 32'h10, 32'h11111111, 1'b1, 32'hDEADBEEF);
      req2("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BADF00D);
      req2("rd10_again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      // Reset in the last WAIT cycle of a write: aborted, never committed.
      @(negedge clk);
      if2.MemWrite  = 1'b1;
      if2.Address   = 32'h20;
      if2.WriteData = 32'hCAFEF00D;
      @(negedge clk);
      check("abort_busy1", 32'(if2.Busy), 32'd1);
      @(negedge clk);
      check("abort_busy2", 32'(if2.Busy), 32'd1);
      check("abort_rdy2", 32'(if2.MemReady), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_rdy", 32'(if2.MemReady), 32'd0);
      check("abort_busy", 32'(if2.Busy), 32'd0);
      check("abort_err", 32'(if2.AddrError), 32'd0);
      check("abort_rdata", if2.ReadData, 32'h0);
      if2.MemWrite = 1'b0;
      @(negedge clk);
      check("abort_rdy_late", 32'(if2.MemReady), 32'd0);
      reset = 1'b0;
      req2("rd20_post_abort", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BADF00D);

      // Word index aliasing: 0x400 maps onto word 0.
      req2("wr400", 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0BADF00D);
      req2("rd000", 1'b1, 1'b0, 32'h000, 32'h0, 1'b0, 32'hA5A5A5A5);

      // Zero wait states, back-to-back with the read held through MemReady.
      req0("z_wr18", 1'b0, 1'b1, 32'h18, 32'h55AA55AA, 32'h0);
      @(negedge clk);
      if0.MemRead = 1'b1;
      if0.Address = 32'h18;
      @(negedge clk);
      check("z_rd18_rdy", 32'(if0.MemReady), 32'd1);
      check("z_rd18_rdata", if0.ReadData, 32'h55AA55AA);
      @(posedge clk);
      #1;
      if0.MemRead   = 1'b0;
      if0.MemWrite  = 1'b1;
      if0.Address   = 32'h14;
      if0.WriteData = 32'h12345678;
      @(negedge clk);
      check("z_gap_rdy", 32'(if0.MemReady), 32'd0);
      check("z_gap_busy", 32'(if0.Busy), 32'd0);
      @(negedge clk);
      check("z_wr14_rdy", 32'(if0.MemReady), 32'd1);
      check("z_wr14_err", 32'(if0.AddrError), 32'd0);
      check("z_wr14_rdata", if0.ReadData, 32'h55AA55AA);
      if0.MemWrite = 1'b0;
      @(negedge clk);
      check("z_wr14_done", 32'(if0.MemReady), 32'd0);
      req0("z_rd14", 1'b1, 1'b0, 32'h14, 32'h0, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
